// File: rtl/pipelined_approx_adder.sv
// pipelined_approx_adder: lower-part-OR approximate adder, one carry segment per stage; define APPROX_ERR_EN for the exact-error monitor
module pipelined_approx_adder #(
    parameter int WIDTH    = 8,
    parameter int SEG_W    = 4,
    parameter int APPROX_K = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef APPROX_ERR_EN
    ,
    output logic [WIDTH:0]   err_dist,
    output logic             err_flag,
    output logic [15:0]      err_count
`endif
);
    localparam int N = WIDTH / SEG_W;

    function automatic logic [WIDTH:0] seg_add(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] p,
        input logic             c,
        input int               s
    );
        logic [WIDTH-1:0] r;
        logic             cy;
        r  = p;
        cy = c;
        for (int i = 0; i < WIDTH; i++) begin
            if (i / SEG_W == s) begin
                if (i < APPROX_K) begin
                    r[i] = x[i] | y[i];
                    cy   = (i == APPROX_K - 1) ? x[i] & y[i] : cy;
                end else begin
                    r[i] = x[i] ^ y[i] ^ cy;
                    cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
                end
            end
        end
        return {cy, r};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] pa [N];
    logic [WIDTH-1:0] pb [N];
    logic [WIDTH-1:0] ps [N];
    logic             pc [N];
    logic             pv [N];
    logic [WIDTH-1:0] ra [N];
    logic [WIDTH-1:0] rb [N];
    logic [WIDTH-1:0] rs [N];
    logic             rc [N];
    logic             rv [N];
    logic [WIDTH:0]   nxt [N];

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = rv[N-1];
    assign sum       = rs[N-1];
    assign cout      = rc[N-1];

    // Stage s sees the ports (s=0) or stage s-1's registers, and adds its own segment
    always_comb begin
        pa[0] = a;
        pb[0] = b;
        ps[0] = '0;
        pc[0] = cin;
        pv[0] = in_valid;
        for (int s = 1; s < N; s++) begin
            pa[s] = ra[s-1];
            pb[s] = rb[s-1];
            ps[s] = rs[s-1];
            pc[s] = rc[s-1];
            pv[s] = rv[s-1];
        end
        for (int s = 0; s < N; s++)
            nxt[s] = seg_add(pa[s], pb[s], ps[s], pc[s], s);
    end

    // Whole pipe moves in lockstep; a stall freezes every stage, bubbles included
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < N; s++) begin
                rv[s] <= 1'b0;
                rc[s] <= 1'b0;
                ra[s] <= '0;
                rb[s] <= '0;
                rs[s] <= '0;
            end
        end else if (adv) begin
            for (int s = 0; s < N; s++) begin
                rv[s]          <= pv[s];
                ra[s]          <= pa[s];
                rb[s]          <= pb[s];
                {rc[s], rs[s]} <= nxt[s];
            end
        end
    end

`ifdef APPROX_ERR_EN
    logic [WIDTH:0] pe [N];
    logic [WIDTH:0] re [N];
    logic [WIDTH:0] appr;

    assign appr     = {cout, sum};
    assign err_dist = (re[N-1] > appr) ? re[N-1] - appr : appr - re[N-1];
    assign err_flag = |err_dist;

    // Exact reference sum enters with the beat and travels beside it
    always_comb begin
        pe[0] = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        for (int s = 1; s < N; s++)
            pe[s] = re[s-1];
    end

    // Exact-sum delay line, stalled together with the approximate pipe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < N; s++)
                re[s] <= '0;
        end else if (adv) begin
            for (int s = 0; s < N; s++)
                re[s] <= pe[s];
        end
    end

    // Count transferred beats that carry an error, sticking at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_count <= '0;
        else if (out_valid && out_ready && err_flag && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pipelined_approx_adder.sv
// tb_pipelined_approx_adder: one DUT per APPROX_K, shared stimulus, table vectors plus scoreboarded random traffic
module tb_pipelined_approx_adder;
    localparam int W  = 8;
    localparam int NK = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
    } beat_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         cin = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ir [NK];
    logic         ov [NK];
    logic         co [NK];
    logic [W-1:0] sm [NK];
`ifdef APPROX_ERR_EN
    logic [W:0]   ed [NK];
    logic         ef [NK];
    logic [15:0]  ec [NK];
`endif

    always #5 clk = ~clk;

    for (genvar k = 0; k < NK; k++) begin : g_dut
        pipelined_approx_adder #(.WIDTH(W), .SEG_W(4), .APPROX_K(k)) dut (
            .clk(clk),
            .rst_n(rst_n),
            .in_valid(in_valid),
            .in_ready(ir[k]),
            .a(a),
            .b(b),
            .cin(cin),
            .out_valid(ov[k]),
            .out_ready(out_ready),
            .sum(sm[k]),
            .cout(co[k])
`ifdef APPROX_ERR_EN
            ,
            .err_dist(ed[k]),
            .err_flag(ef[k]),
            .err_count(ec[k])
`endif
        );
    end

    int          pass = 0;
    int          total = 0;
    beat_t       q[$];
    int unsigned ecnt_m [NK];
    logic        acc;
    logic        got;
    logic [7:0]  gs;
    logic        gc;
    vec_t        tbl [7];

    // LOA reference: OR below k, carry seeded from bit k-1, plain addition above
    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic c, input int k);
        int unsigned lo, hi, cc;
        if (k == 0) return 9'(int'(x) + int'(y) + int'(c));
        lo = (int'(x) | int'(y)) & ((1 << k) - 1);
        cc = ((int'(x) >> (k - 1)) & (int'(y) >> (k - 1))) & 1;
        hi = (int'(x) >> k) + (int'(y) >> k) + cc;
        return 9'((hi << k) | lo);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cycle(input logic iv, input logic [7:0] x, input logic [7:0] y, input logic c,
                         input logic orr, input logic rn);
        beat_t      bt;
        logic [8:0] e;
        logic [8:0] ex;
        logic [8:0] d;
        @(negedge clk);
        in_valid  = iv;
        a         = x;
        b         = y;
        cin       = c;
        out_ready = orr;
        rst_n     = rn;
        #1;
        acc = 1'b0;
        if (!rn) begin
            q.delete();
            for (int k = 0; k < NK; k++) ecnt_m[k] = 0;
        end else begin
            if (ov[0] && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", ov[0], 0);
                end else begin
                    bt  = q.pop_front();
                    got = 1'b1;
                    gs  = sm[2];
                    gc  = co[2];
                    ex  = 9'(int'(bt.a) + int'(bt.b) + int'(bt.c));
                    for (int k = 0; k < NK; k++) begin
                        e = model(bt.a, bt.b, bt.c, k);
                        chk($sformatf("sum_k%0d", k), sm[k], e[7:0]);
                        chk($sformatf("cout_k%0d", k), co[k], e[8]);
                        d = (ex > e) ? ex - e : e - ex;
`ifdef APPROX_ERR_EN
                        chk($sformatf("err_dist_k%0d", k), ed[k], d);
                        chk($sformatf("err_flag_k%0d", k), ef[k], d != 0);
`endif
                        if (d != 0 && ecnt_m[k] != 32'hFFFF) ecnt_m[k]++;
                    end
                end
            end
            if (iv && ir[0]) begin
                q.push_back('{a: x, b: y, c: c});
                acc = 1'b1;
            end
        end
    endtask

    initial begin
        int idx;
        int n;
        int acc_cnt;
        beat_t fb [4];
        tbl[0] = '{a: 8'h0F, b: 8'h01, c: 1'b0, s: 8'h0F, co: 1'b0};
        tbl[1] = '{a: 8'h03, b: 8'h03, c: 1'b1, s: 8'h07, co: 1'b0};
        tbl[2] = '{a: 8'hFF, b: 8'h01, c: 1'b0, s: 8'hFF, co: 1'b0};
        tbl[3] = '{a: 8'hFF, b: 8'hFF, c: 1'b0, s: 8'hFF, co: 1'b1};
        tbl[4] = '{a: 8'h80, b: 8'h80, c: 1'b1, s: 8'h00, co: 1'b1};
        tbl[5] = '{a: 8'h00, b: 8'h00, c: 1'b1, s: 8'h00, co: 1'b0};
        tbl[6] = '{a: 8'h0A, b: 8'h06, c: 1'b0, s: 8'h12, co: 1'b0};
        for (int k = 0; k < NK; k++) ecnt_m[k] = 0;

        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < NK; k += 3) begin
            chk($sformatf("rst_out_valid_k%0d", k), ov[k], 0);
            chk($sformatf("rst_sum_k%0d", k), sm[k], 0);
            chk($sformatf("rst_cout_k%0d", k), co[k], 0);
            chk($sformatf("rst_in_ready_k%0d", k), ir[k], 1);
        end

        for (int v = 0; v < 7; v++) begin
            got = 1'b0;
            cycle(1, tbl[v].a, tbl[v].b, tbl[v].c, 1, 1);
            chk($sformatf("tbl%0d_accept", v), acc, 1);
            n = 0;
            while (!got && n < 10) begin
                cycle(0, 0, 0, 0, 1, 1);
                n++;
            end
            chk($sformatf("tbl%0d_arrived", v), got, 1);
            chk($sformatf("tbl%0d_sum", v), gs, tbl[v].s);
            chk($sformatf("tbl%0d_cout", v), gc, tbl[v].co);
        end

        cycle(1, 8'hFF, 8'h01, 1, 1, 1);
        cycle(0, 0, 0, 0, 1, 1);
        chk("lat_early", ov[0], 0);
        cycle(0, 0, 0, 0, 1, 1);
        chk("lat_valid", ov[0], 1);
        chk("lat_sum", sm[0], 8'h01);
        chk("lat_cout", co[0], 1);
        cycle(0, 0, 0, 0, 1, 1);

        fb[0] = '{a: 8'h12, b: 8'h34, c: 1'b1};
        fb[1] = '{a: 8'hA5, b: 8'h5A, c: 1'b0};
        fb[2] = '{a: 8'h7F, b: 8'h81, c: 1'b1};
        fb[3] = '{a: 8'hC3, b: 8'h3C, c: 1'b0};
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1, fb[idx].a, fb[idx].b, fb[idx].c, 0, 1);
            if (acc) idx++;
        end
        chk("fill_accepted", idx, 2);
        chk("fill_stall", ir[0], 0);
        chk("fill_held_valid", ov[0], 1);
        n = 0;
        while (idx < 4 && n < 20) begin
            cycle(1, fb[idx].a, fb[idx].b, fb[idx].c, 1, 1);
            if (acc) idx++;
            n++;
        end
        chk("drain_accepted", idx, 4);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, 1);
        chk("drain_empty", q.size(), 0);

        cycle(1, 8'h11, 8'h22, 0, 0, 1);
        cycle(1, 8'h33, 8'h44, 1, 0, 1);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 1);
        for (int k = 0; k < NK; k += 2) begin
            chk($sformatf("rrst_out_valid_k%0d", k), ov[k], 0);
            chk($sformatf("rrst_sum_k%0d", k), sm[k], 0);
            chk($sformatf("rrst_cout_k%0d", k), co[k], 0);
            chk($sformatf("rrst_in_ready_k%0d", k), ir[k], 1);
`ifdef APPROX_ERR_EN
            chk($sformatf("rrst_err_count_k%0d", k), ec[k], 0);
`endif
        end
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 1, 1);
            chk("no_stale", ov[0], 0);
        end

        acc_cnt = 0;
        n = 0;
        while (acc_cnt < 10000 && n < 40000) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0, 1);
            if (acc) acc_cnt++;
            n++;
        end
        chk("rand_accepted", acc_cnt, 10000);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 1);
        chk("rand_empty", q.size(), 0);
`ifdef APPROX_ERR_EN
        for (int k = 0; k < NK; k++)
            chk($sformatf("err_count_k%0d", k), ec[k], ecnt_m[k]);
`endif

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
